lsu_mem_arbiter: RTL

- Shares the single data-memory port between two requesters:
  - port 0: core load/store path (byte-enable mask and write data already formatted by the load/store unit);
  - port 1: DMA/debug master.
- Round-robin arbitration, one outstanding transaction at a time.
- Sequences the memory handshake (active-low chip select, ack), enforces a timeout and returns read data or an error to the owner.

---
 rtl/lsu_mem_arbiter_if.sv | 74 +++++++
 rtl/lsu_mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/lsu_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_arbiter_if
//   Bundles every bus signal around lsu_mem_arbiter: the two requester ports
//   (p0 = core load/store path, p1 = DMA/debug master) and the single shared
//   data-memory port.
//
//   Handshake semantics (shared by both requester ports):
//     pN_req is raised together with pN_we/addr/wdata/mask and held stable
//     until pN_gnt is seen high; the request fields are captured on the clock
//     edge that ends the pN_gnt cycle and are don't-care afterwards.
//     pN_rvalid is a one-cycle completion pulse; pN_rdata/pN_err are only
//     meaningful while pN_rvalid is high.
//     On the memory side mem_cs (active low) is held low for the whole access
//     with mem_we/addr/wdata/mask stable; mem_ack (with mem_rdata) ends it.
//
//   Modports:
//     slave  - the arbiter's view (requests and memory response in,
//              grants, completions and memory command out).
//     master - the environment's view (the mirror image).
//   dbg_state exposes the arbiter FSM state (0 IDLE, 1 BUSY, 2 RESP).
// -----------------------------------------------------------------------------
interface lsu_mem_arbiter_if #(
    parameter int AW = 32
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [31:0]   p0_wdata;
    logic [3:0]    p0_mask;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [31:0]   p0_rdata;
    logic          p0_err;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [31:0]   p1_wdata;
    logic [3:0]    p1_mask;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [31:0]   p1_rdata;
    logic          p1_err;

    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_mask;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    logic [1:0]    dbg_state;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_mask,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_mask,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_cs, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_rdata, mem_ack,
        output dbg_state
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_mask,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_mask,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_cs, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_rdata, mem_ack,
        input  dbg_state
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_mem_arbiter
//   Shares one data-memory port between the core load/store path (port 0)
//   and a DMA/debug master (port 1). Round-robin arbitration, a single
//   outstanding transaction, active-low chip select with ack handshake and a
//   timeout that completes the transaction with an error flag.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - synchronous active-low reset
//     bus    - lsu_mem_arbiter_if.slave: requester ports p0/p1, memory port,
//              FSM debug state
//
//   Parameters:
//     TIMEOUT - BUSY cycles without mem_ack before abort (2..255)
//     AW      - address width
//
//   Timing: grant is combinational in IDLE, the access runs in BUSY
//   (>= 1 cycle), completion is signalled in RESP, so one transaction takes
//   at least 3 cycles and req-to-rvalid is at least 2 cycles.
// -----------------------------------------------------------------------------
module lsu_mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e        state_q;
    logic          owner_q;
    logic          last_owner_q;
    logic [7:0]    cnt_q;

    logic          mem_cs_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_mask_q;

    logic [1:0]    rvalid_q;
    logic [1:0]    err_q;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_q;

    logic          any_req;
    logic          winner;
    logic          grant;
    logic          done;
    logic [31:0]   resp_rdata;

    // A lone requester wins outright; under contention the port that did
    // not own the previous transaction wins.
    assign any_req = bus.p0_req | bus.p1_req;
    assign winner  = (bus.p0_req & bus.p1_req) ? ~last_owner_q : bus.p1_req;
    assign grant   = rst_n && (state_q == ST_IDLE) && any_req;

    // Ack wins over the timeout when both land in the same cycle.
    assign done       = bus.mem_ack || (cnt_q == CNT_LAST);
    // Stores and timeouts return zero data.
    assign resp_rdata = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cnt_q        <= 8'd0;
            mem_cs_q     <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_mask_q   <= 4'h0;
            rvalid_q     <= 2'b00;
            err_q        <= 2'b00;
            rdata0_q     <= 32'h0;
            rdata1_q     <= 32'h0;
        end else begin
            rvalid_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        mem_we_q     <= winner ? bus.p1_we    : bus.p0_we;
                        mem_addr_q   <= winner ? bus.p1_addr  : bus.p0_addr;
                        mem_wdata_q  <= winner ? bus.p1_wdata : bus.p0_wdata;
                        mem_mask_q   <= winner ? bus.p1_mask  : bus.p0_mask;
                        mem_cs_q     <= 1'b0;
                        owner_q      <= winner;
                        last_owner_q <= winner;
                        cnt_q        <= 8'd0;
                        state_q      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        if (owner_q) begin
                            rdata1_q <= resp_rdata;
                            err_q[1] <= ~bus.mem_ack;
                        end else begin
                            rdata0_q <= resp_rdata;
                            err_q[0] <= ~bus.mem_ack;
                        end
                        rvalid_q[owner_q] <= 1'b1;
                        mem_cs_q          <= 1'b1;
                        state_q           <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_cs_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.p0_gnt    = grant & ~winner;
    assign bus.p1_gnt    = grant & winner;
    assign bus.p0_rvalid = rvalid_q[0];
    assign bus.p1_rvalid = rvalid_q[1];
    assign bus.p0_rdata  = rdata0_q;
    assign bus.p1_rdata  = rdata1_q;
    assign bus.p0_err    = err_q[0];
    assign bus.p1_err    = err_q[1];

    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_mask  = mem_mask_q;

    assign bus.dbg_state = state_q;

endmodule
